hop_phase_sequencer: RTL and testbench

//  Upstream control stage for the two-tone tag-chip DDS generator. Owns a writable table of per-hop

---
 rtl/hop_phase_sequencer_if.sv | 40 ++++
 rtl/hop_phase_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_hop_phase_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hop_phase_sequencer_if.sv
// Control/data bundle between the hop sequencer and its environment.
// Latency: none (wires only).
// Backpressure: none; the generator paces hops via the sticky hop_ready flag.
//
// Ports carried (all plain signals):
//   config side : run, cfg_mode, cfg_nhop, cfg_wr_en, cfg_addr, cfg_data
//   generator   : hop_ready (in), hop_phase_inc, gen_tvalid, gen_srst (out)
//   status      : hop_index, hop_cnt, frame_done, busy
// The "master" modport is the environment (config + generator).
// The "slave" modport is the sequencer itself.
interface hop_phase_sequencer_if #(
    parameter int PHASE_WIDTH = 24,
    parameter int ADDR_WIDTH  = 6
);
    logic                   run;
    logic                   cfg_mode;
    logic [ADDR_WIDTH-1:0]  cfg_nhop;
    logic                   cfg_wr_en;
    logic [ADDR_WIDTH-1:0]  cfg_addr;
    logic [PHASE_WIDTH-1:0] cfg_data;
    logic                   hop_ready;

    logic [PHASE_WIDTH-1:0] hop_phase_inc;
    logic                   gen_tvalid;
    logic                   gen_srst;
    logic [ADDR_WIDTH-1:0]  hop_index;
    logic [15:0]            hop_cnt;
    logic                   frame_done;
    logic                   busy;

    modport master (
        output run, cfg_mode, cfg_nhop, cfg_wr_en, cfg_addr, cfg_data, hop_ready,
        input  hop_phase_inc, gen_tvalid, gen_srst, hop_index, hop_cnt, frame_done, busy
    );

    modport slave (
        input  run, cfg_mode, cfg_nhop, cfg_wr_en, cfg_addr, cfg_data, hop_ready,
        output hop_phase_inc, gen_tvalid, gen_srst, hop_index, hop_cnt, frame_done, busy
    );
endinterface

// File: rtl/hop_phase_sequencer.sv
// Per-hop phase-increment sequencer feeding the two-tone DDS generator.
// Latency: run->gen_srst 3 cycles, hop_ready rise->next gen_srst 3 cycles (+LFSR rejections).
// Backpressure: next hop starts only after a new rising edge of the generator's hop_ready.
//
// Ports:
//   clk, aresetn : clock, asynchronous active-low reset
//   bus (slave)  : config inputs, table write port, generator handshake and status
//                  outputs (see hop_phase_sequencer_if).
// The table address is at most 8 bits wide because LFSR candidates come from
// the low bits of an 8-bit LFSR.
module hop_phase_sequencer #(
    parameter int         PHASE_WIDTH = 24,
    parameter int         ADDR_WIDTH  = 6,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  aresetn,
    hop_phase_sequencer_if.slave  bus
);

    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0] SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_FETCH,
        S_PRIME,
        S_RUN
    } state_t;

    state_t                 state;

    // Phase table; contents survive reset.
    logic [PHASE_WIDTH-1:0] mem [DEPTH];

    logic                   mode_q;       // 0 linear, 1 LFSR
    logic [ADDR_WIDTH-1:0]  nhop_q;       // active entries, never 0
    logic [ADDR_WIDTH-1:0]  idx_q;        // hop chosen in PICK
    logic [ADDR_WIDTH-1:0]  frame_cnt;    // completed hops within the frame
    logic                   first_q;      // next linear pick is the first of a run
    logic [7:0]             lfsr;
    logic                   ready_prev;

    logic [PHASE_WIDTH-1:0] phase_q;
    logic                   tvalid_q;
    logic                   srst_q;
    logic [ADDR_WIDTH-1:0]  index_q;
    logic [15:0]            cnt_q;
    logic                   fdone_q;
    logic                   busy_q;

    // Next-state helpers
    logic [7:0]             lfsr_next;
    logic [ADDR_WIDTH-1:0]  cand;
    logic [ADDR_WIDTH-1:0]  idx_inc;
    logic [ADDR_WIDTH-1:0]  idx_lin;
    logic [ADDR_WIDTH-1:0]  nhop_in;
    logic                   hop_rise;
    logic                   frame_last;

    always_comb begin
        // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting towards the MSB.
        lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        cand       = lfsr_next[ADDR_WIDTH-1:0];
        idx_inc    = idx_q + 1'b1;
        if (first_q) begin
            idx_lin = '0;
        end else if (idx_inc == nhop_q) begin
            idx_lin = '0;
        end else begin
            idx_lin = idx_inc;
        end
        nhop_in    = (bus.cfg_nhop == '0) ? {{(ADDR_WIDTH-1){1'b0}}, 1'b1} : bus.cfg_nhop;
        hop_rise   = bus.hop_ready & ~ready_prev;
        frame_last = (frame_cnt == nhop_q - 1'b1);
    end

    // Table write port. The read happens in the FSM block on the same edge,
    // so a same-cycle write to the address being read returns the old data.
    always_ff @(posedge clk) begin
        if (bus.cfg_wr_en) begin
            mem[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            mode_q     <= 1'b0;
            nhop_q     <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            idx_q      <= '0;
            frame_cnt  <= '0;
            first_q    <= 1'b0;
            lfsr       <= SEED_EFF;
            ready_prev <= 1'b0;
            phase_q    <= '0;
            tvalid_q   <= 1'b0;
            srst_q     <= 1'b0;
            index_q    <= '0;
            cnt_q      <= '0;
            fdone_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Pulse outputs default low; the edge detector tracks hop_ready
            // continuously, so a flag already high when RUN is entered is
            // not mistaken for a new completion.
            srst_q     <= 1'b0;
            fdone_q    <= 1'b0;
            ready_prev <= bus.hop_ready;

            case (state)
                S_IDLE: begin
                    tvalid_q <= 1'b0;
                    if (bus.run) begin
                        mode_q    <= bus.cfg_mode;
                        nhop_q    <= nhop_in;
                        cnt_q     <= '0;
                        frame_cnt <= '0;
                        first_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= S_PICK;
                    end
                end

                S_PICK: begin
                    if (!mode_q) begin
                        idx_q   <= idx_lin;
                        first_q <= 1'b0;
                        state   <= S_FETCH;
                    end else begin
                        // One LFSR step per cycle; out-of-range candidates
                        // are rejected. A maximal-length LFSR visits every
                        // nonzero value, so an in-range one appears within
                        // 255 steps.
                        lfsr <= lfsr_next;
                        if (cand < nhop_q) begin
                            idx_q   <= cand;
                            first_q <= 1'b0;
                            state   <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    // The RAM output register is hop_phase_inc itself, so the
                    // new increment, index and srst all appear together on
                    // entry to PRIME.
                    phase_q <= mem[idx_q];
                    index_q <= idx_q;
                    srst_q  <= 1'b1;
                    cnt_q   <= cnt_q + 16'd1;
                    state   <= S_PRIME;
                end

                S_PRIME: begin
                    tvalid_q <= 1'b1;
                    state    <= S_RUN;
                end

                S_RUN: begin
                    if (hop_rise) begin
                        if (frame_last) begin
                            fdone_q   <= 1'b1;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                        tvalid_q <= 1'b0;
                        if (bus.run) begin
                            state <= S_PICK;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end
                end

                default: begin
                    tvalid_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hop_phase_inc = phase_q;
    assign bus.gen_tvalid    = tvalid_q;
    assign bus.gen_srst      = srst_q;
    assign bus.hop_index     = index_q;
    assign bus.hop_cnt       = cnt_q;
    assign bus.frame_done    = fdone_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_hop_phase_sequencer.sv
// Directed bench for hop_phase_sequencer with an expected-hop scoreboard.
// Latency: n/a.
// Backpressure: the bench plays the generator, raising hop_ready ~20 cycles after each srst.
module tb_hop_phase_sequencer;

    localparam int PW = 24;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic aresetn;

    always #5 clk = ~clk;

    hop_phase_sequencer_if #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

    hop_phase_sequencer #(
        .PHASE_WIDTH(PW),
        .ADDR_WIDTH (AW),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk    (clk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    typedef struct {
        int            idx;
        logic [PW-1:0] ph;
        int            lat;
        logic [15:0]   cnt;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;

    // Reference model state
    logic [PW-1:0] m_tab [64];
    int            m_idx;
    bit            m_first;
    int            m_nhop;
    bit            m_mode;
    logic [7:0]    m_lfsr;
    int            m_fc;
    logic [15:0]   m_cnt;
    logic [PW-1:0] last_ph;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Predict the next hop and queue it.
    function automatic void push_exp();
        exp_t e;
        int   picks;
        if (!m_mode) begin
            if (m_first)                 m_idx = 0;
            else if (m_idx + 1 == m_nhop) m_idx = 0;
            else                          m_idx = m_idx + 1;
            picks = 1;
        end else begin
            picks = 0;
            do begin
                m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
                picks++;
            end while (int'(m_lfsr[5:0]) >= m_nhop);
            m_idx = int'(m_lfsr[5:0]);
        end
        m_first = 1'b0;
        m_cnt   = m_cnt + 16'd1;
        e.idx   = m_idx;
        e.ph    = m_tab[m_idx];
        e.lat   = 2 + picks;
        e.cnt   = m_cnt;
        sb.push_back(e);
    endfunction

    // Model a hop completion; returns the expected frame_done.
    function automatic bit complete_hop();
        if (m_fc == m_nhop - 1) begin
            m_fc = 0;
            return 1'b1;
        end
        m_fc = m_fc + 1;
        return 1'b0;
    endfunction

    // Called on the negedge where a trigger (run or hop_ready) was just driven.
    task automatic serve(input bit fd_exp, input bit do_wr, input int wa, input logic [PW-1:0] wd);
        int   lat;
        exp_t e;
        lat = 0;
        while (!bus.gen_srst && lat < 400) begin
            step();
            lat++;
            if (lat == 1) chk("frame_done", 32'(bus.frame_done), 32'(fd_exp));
            if (do_wr && lat == 2) begin
                bus.cfg_wr_en = 1'b1;
                bus.cfg_addr  = wa[AW-1:0];
                bus.cfg_data  = wd;
            end
        end
        bus.cfg_wr_en = 1'b0;
        if (do_wr) m_tab[wa] = wd;
        chk("srst_timeout", 32'(lat < 400), 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("srst_latency", lat, e.lat);
            chk("hop_index", 32'(bus.hop_index), e.idx);
            chk("hop_phase_inc", 32'(bus.hop_phase_inc), 32'(e.ph));
            chk("hop_cnt", 32'(bus.hop_cnt), 32'(e.cnt));
            chk("index_range", 32'(int'(bus.hop_index) < m_nhop), 32'd1);
            last_ph = e.ph;
        end
        chk("tvalid_prime", 32'(bus.gen_tvalid), 32'd0);
        chk("busy_prime", 32'(bus.busy), 32'd1);
        bus.hop_ready = 1'b0;
        step();
        chk("tvalid_run", 32'(bus.gen_tvalid), 32'd1);
        chk("srst_one_cycle", 32'(bus.gen_srst), 32'd0);
        repeat (18) step();
        chk("phase_stable", 32'(bus.hop_phase_inc), 32'(last_ph));
    endtask

    task automatic start_run(input bit mode, input int nhop);
        bus.cfg_mode = mode;
        bus.cfg_nhop = nhop[AW-1:0];
        m_mode  = mode;
        m_nhop  = (nhop == 0) ? 1 : nhop;
        m_first = 1'b1;
        m_fc    = 0;
        m_cnt   = 16'd0;
        push_exp();
        bus.run = 1'b1;
        serve(1'b0, 1'b0, 0, '0);
    endtask

    task automatic next_hop(input bit do_wr, input int wa, input logic [PW-1:0] wd);
        bit fd;
        fd = complete_hop();
        push_exp();
        bus.hop_ready = 1'b1;
        serve(fd, do_wr, wa, wd);
    endtask

    task automatic stop_run();
        bit fd;
        int n_srst;
        bus.run = 1'b0;
        repeat (4) step();
        chk("tvalid_after_run_drop", 32'(bus.gen_tvalid), 32'd1);
        chk("busy_after_run_drop", 32'(bus.busy), 32'd1);
        fd = complete_hop();
        bus.hop_ready = 1'b1;
        step();
        chk("frame_done_stop", 32'(bus.frame_done), 32'(fd));
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("tvalid_idle", 32'(bus.gen_tvalid), 32'd0);
        n_srst = 0;
        repeat (30) begin
            step();
            if (bus.gen_srst) n_srst++;
        end
        chk("no_srst_idle", n_srst, 0);
        chk("phase_held_idle", 32'(bus.hop_phase_inc), 32'(last_ph));
        chk("index_held_idle", 32'(bus.hop_index), m_idx);
        bus.hop_ready = 1'b0;
        step();
    endtask

    initial begin
        int   lat;
        exp_t e;

        aresetn       = 1'b0;
        bus.run       = 1'b0;
        bus.cfg_mode  = 1'b0;
        bus.cfg_nhop  = '0;
        bus.cfg_wr_en = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.hop_ready = 1'b0;
        m_lfsr        = 8'hA5;
        m_idx         = 0;
        last_ph       = '0;
        repeat (3) step();

        // Reset state
        chk("rst_phase", 32'(bus.hop_phase_inc), 32'd0);
        chk("rst_tvalid", 32'(bus.gen_tvalid), 32'd0);
        chk("rst_srst", 32'(bus.gen_srst), 32'd0);
        chk("rst_index", 32'(bus.hop_index), 32'd0);
        chk("rst_cnt", 32'(bus.hop_cnt), 32'd0);
        chk("rst_fdone", 32'(bus.frame_done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        aresetn = 1'b1;
        step();

        // Load table[i] = 1000*(i+1)
        for (int i = 0; i < 8; i++) begin
            m_tab[i]      = PW'(1000 * (i + 1));
            bus.cfg_wr_en = 1'b1;
            bus.cfg_addr  = i[AW-1:0];
            bus.cfg_data  = m_tab[i];
            step();
        end
        bus.cfg_wr_en = 1'b0;
        step();

        // Linear, nhop=4: 1000,2000,3000,4000,1000; then drop run mid-hop
        start_run(1'b0, 4);
        for (int i = 0; i < 4; i++) next_hop(1'b0, 0, '0);
        stop_run();

        // Same-cycle write to the entry being fetched
        start_run(1'b0, 4);
        next_hop(1'b0, 0, '0);
        next_hop(1'b1, 2, 24'd7777);
        for (int i = 0; i < 4; i++) next_hop(1'b0, 0, '0);
        stop_run();

        // LFSR order, nhop=5
        start_run(1'b1, 5);
        for (int i = 0; i < 10; i++) next_hop(1'b0, 0, '0);
        stop_run();

        // nhop=0 behaves as a single-entry frame
        start_run(1'b0, 0);
        for (int i = 0; i < 3; i++) next_hop(1'b0, 0, '0);
        stop_run();

        // Asynchronous reset while in PRIME
        bus.cfg_mode = 1'b0;
        bus.cfg_nhop = 6'd4;
        m_mode  = 1'b0;
        m_nhop  = 4;
        m_first = 1'b1;
        m_fc    = 0;
        m_cnt   = 16'd0;
        push_exp();
        bus.run = 1'b1;
        lat = 0;
        while (!bus.gen_srst && lat < 400) begin
            step();
            lat++;
        end
        chk("prime_srst_timeout", 32'(lat < 400), 32'd1);
        e = sb.pop_front();
        chk("prime_phase", 32'(bus.hop_phase_inc), 32'(e.ph));
        aresetn = 1'b0;
        #1;
        chk("arst_phase", 32'(bus.hop_phase_inc), 32'd0);
        chk("arst_tvalid", 32'(bus.gen_tvalid), 32'd0);
        chk("arst_srst", 32'(bus.gen_srst), 32'd0);
        chk("arst_index", 32'(bus.hop_index), 32'd0);
        chk("arst_cnt", 32'(bus.hop_cnt), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        bus.run = 1'b0;
        repeat (2) step();
        aresetn = 1'b1;
        m_lfsr  = 8'hA5;
        step();
        start_run(1'b0, 4);
        next_hop(1'b0, 0, '0);
        stop_run();
        // LFSR restarts from the seed after reset
        start_run(1'b1, 5);
        for (int i = 0; i < 3; i++) next_hop(1'b0, 0, '0);
        stop_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
